// File: rtl/bsc_pkg.sv
// Shared opcode, ALU function and state encodings for the bit-serial CPU control sequencer.
package bsc_pkg;

   localparam logic [3:0] OP_ADD     = 4'h0;
   localparam logic [3:0] OP_SUB     = 4'h1;
   localparam logic [3:0] OP_SLLI    = 4'h2;
   localparam logic [3:0] OP_SRLI    = 4'h3;
   localparam logic [3:0] OP_XOR     = 4'h4;
   localparam logic [3:0] OP_AND     = 4'h5;
   localparam logic [3:0] OP_OR      = 4'h6;
   localparam logic [3:0] OP_LOADI   = 4'h7;
   localparam logic [3:0] OP_LOAD    = 4'hD;
   localparam logic [3:0] OP_STORE   = 4'hE;
   localparam logic [3:0] OP_ILLEGAL = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DECODE  = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_OUTPUT  = 3'd3,
      ST_ILLEGAL = 3'd4
   } state_t;

endpackage

// File: rtl/bsc_alu_decode.sv
// Combinational opcode decoder: ALU function plus instruction class flags.
module bsc_alu_decode
   import bsc_pkg::*;
(
   input  logic [3:0] opcode,
   output logic [2:0] alu_op,
   output logic       is_shift,
   output logic       is_load,
   output logic       is_store,
   output logic       is_illegal
);

   // Unassigned encodings other than 4'hF run as a single ADD pass.
   always_comb begin
      alu_op     = ALU_ADD;
      is_shift   = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_illegal = 1'b0;
      case (opcode)
         OP_ADD:     alu_op = ALU_ADD;
         OP_SUB:     alu_op = ALU_SUB;
         OP_XOR:     alu_op = ALU_XOR;
         OP_AND:     alu_op = ALU_AND;
         OP_OR:      alu_op = ALU_OR;
         OP_SLLI: begin
            alu_op   = ALU_SLL;
            is_shift = 1'b1;
         end
         OP_SRLI: begin
            alu_op   = ALU_SRL;
            is_shift = 1'b1;
         end
         OP_LOADI,
         OP_LOAD:    is_load    = 1'b1;
         OP_STORE:   is_store   = 1'b1;
         OP_ILLEGAL: is_illegal = 1'b1;
         default:    alu_op     = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/bsc_seq_control.sv
// Control sequencer for the bit-serial CPU: valid/ready instruction intake, internal bit and
// pass counters, multi-pass shifts and illegal-opcode rejection.
module bsc_seq_control
   import bsc_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int SHAMT_W = $clog2(DATA_W),
   localparam int CNT_W   = $clog2(DATA_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               inst_valid,
   output logic               inst_ready,
   input  logic [3:0]         opcode,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [2:0]         alu_op,
   output logic               alu_start,
   output logic               alu_en,
   output logic               reg_shift_en,
   output logic               acc_write_en,
   output logic               acc_load_en,
   output logic               reg_store_en,
   output logic [CNT_W-1:0]   bit_idx,
   output logic               busy,
   output logic               out_en,
   output logic               done,
   output logic               illegal
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   bit_cnt;
   logic [SHAMT_W-1:0] pass_cnt;
   logic [3:0]         op_q;
   logic [SHAMT_W-1:0] shamt_q;

   logic [2:0] dec_alu_op;
   logic       dec_shift;
   logic       dec_load;
   logic       dec_store;
   logic       dec_illegal;

   bsc_alu_decode u_decode (
      .opcode     (op_q),
      .alu_op     (dec_alu_op),
      .is_shift   (dec_shift),
      .is_load    (dec_load),
      .is_store   (dec_store),
      .is_illegal (dec_illegal)
   );

   // Each pass ends on the last bit; the pass counter is loaded in DECODE so SHIFT starts at bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         pass_cnt <= '0;
         op_q     <= '0;
         shamt_q  <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && inst_valid) begin
            op_q    <= opcode;
            shamt_q <= shamt;
         end
         case (state)
            ST_DECODE: begin
               bit_cnt  <= '0;
               pass_cnt <= dec_shift ? shamt_q : SHAMT_W'(1);
            end
            ST_SHIFT: begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt  <= '0;
                  pass_cnt <= pass_cnt - SHAMT_W'(1);
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (inst_valid)
               state_next = (opcode == OP_ILLEGAL) ? ST_ILLEGAL : ST_DECODE;
         end
         ST_DECODE: begin
            if (dec_load || dec_store || (dec_shift && shamt_q == '0))
               state_next = ST_OUTPUT;
            else
               state_next = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (bit_cnt == LAST_BIT && pass_cnt == SHAMT_W'(1))
               state_next = ST_OUTPUT;
         end
         ST_OUTPUT:  state_next = ST_IDLE;
         ST_ILLEGAL: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Outputs are pure state decode, forced low for as long as reset is held.
   always_comb begin
      inst_ready   = 1'b0;
      alu_op       = '0;
      alu_start    = 1'b0;
      alu_en       = 1'b0;
      reg_shift_en = 1'b0;
      acc_write_en = 1'b0;
      acc_load_en  = 1'b0;
      reg_store_en = 1'b0;
      bit_idx      = '0;
      busy         = 1'b0;
      out_en       = 1'b0;
      done         = 1'b0;
      illegal      = 1'b0;
      if (!rst) begin
         busy    = (state != ST_IDLE);
         bit_idx = bit_cnt;
         case (state)
            ST_IDLE: inst_ready = 1'b1;
            ST_DECODE: begin
               alu_op       = dec_alu_op;
               acc_load_en  = dec_load;
               reg_store_en = dec_store;
            end
            ST_SHIFT: begin
               alu_op       = dec_alu_op;
               alu_en       = 1'b1;
               reg_shift_en = 1'b1;
               acc_write_en = 1'b1;
               alu_start    = (bit_cnt == '0);
            end
            ST_OUTPUT: begin
               out_en = 1'b1;
               done   = 1'b1;
            end
            ST_ILLEGAL: illegal = dec_illegal;
            default: ;
         endcase
      end
   end

endmodule
